// File: rtl/turn_signal_if.sv
// Request/command bundle between the switch inputs, the sequencing controller
// and the six-lamp light FSM.
interface turn_signal_if;
    logic       left_req;
    logic       right_req;
    logic       hazard_req;
    logic       step_en;
    logic       fsm_left;
    logic       fsm_right;
    logic [1:0] mode;
    logic       busy;
    logic [7:0] seq_count;

    // Switch side / observer: drives the raw requests, watches the commands.
    modport master (
        output left_req,
        output right_req,
        output hazard_req,
        input  step_en,
        input  fsm_left,
        input  fsm_right,
        input  mode,
        input  busy,
        input  seq_count
    );

    // Controller side: consumes the raw requests, produces the commands.
    modport slave (
        input  left_req,
        input  right_req,
        input  hazard_req,
        output step_en,
        output fsm_left,
        output fsm_right,
        output mode,
        output busy,
        output seq_count
    );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn-signal sequencing controller: synchronises the left/right/hazard
// switches, arbitrates them into a mode, and paces the light FSM one lamp
// step per step_en pulse. The mode only changes at sequence boundaries, and
// GAP_STEPS dark steps separate consecutive sequences.
module turn_signal_ctrl #(
    parameter int STEP_DIV  = 12500000,
    parameter int DIV_W     = 24,
    parameter int GAP_STEPS = 1
) (
    input  logic          clk,
    input  logic          reset,
    turn_signal_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    // gap_cnt never needs to hold more than GAP_STEPS-1
    localparam int               GAP_W    = (GAP_STEPS > 2) ? $clog2(GAP_STEPS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_STEPS > 0) ? (GAP_STEPS - 1) : 0);
    localparam bit               HAS_GAP  = (GAP_STEPS > 0);

    // Hazard wins; left+right together is also treated as hazard.
    function automatic logic [1:0] arbitrate(input logic [2:0] req);
        logic [1:0] res;
        if (req[2] || (req[0] && req[1])) begin
            res = MODE_HAZARD;
        end else if (req[0]) begin
            res = MODE_LEFT;
        end else if (req[1]) begin
            res = MODE_RIGHT;
        end else begin
            res = MODE_NONE;
        end
        return res;
    endfunction

    // Saturating sequence counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        logic [7:0] res;
        if (val != 8'hFF) begin
            res = val + 8'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // request bit order: [2]=hazard, [1]=right, [0]=left
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    state_t           state_q,  state_d;
    logic [1:0]       mode_q,   mode_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [1:0]       step_q,   step_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic [7:0]       seq_q,    seq_d;
    logic [1:0]       pri_s;
    logic             step_en_s;

    assign pri_s     = arbitrate(sync2_q);
    assign step_en_s = (state_q != ST_IDLE) && (div_q == DIV_LAST);

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {bus.hazard_req, bus.right_req, bus.left_req};
            sync2_q <= sync1_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NONE;
            div_q   <= '0;
            step_q  <= 2'd0;
            gap_q   <= '0;
            seq_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            step_q  <= step_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
        end
    end

    // Next-state logic: divider, step/gap counting and boundary re-arbitration.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        step_d  = step_q;
        gap_d   = gap_q;
        seq_d   = seq_q;

        if (state_q != ST_IDLE) begin
            if (step_en_s) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pri_s != MODE_NONE) begin
                    mode_d  = pri_s;
                    div_d   = '0;
                    step_d  = 2'd0;
                    state_d = ST_RUN;
                end else begin
                    mode_d  = MODE_NONE;
                end
            end
            ST_RUN: begin
                if (step_en_s) begin
                    if (step_q == 2'd3) begin
                        // fourth pulse: light FSM is back in S0
                        seq_d  = sat_inc(seq_q);
                        step_d = 2'd0;
                        if (HAS_GAP) begin
                            mode_d  = MODE_NONE;
                            gap_d   = '0;
                            state_d = ST_GAP;
                        end else if (pri_s != MODE_NONE) begin
                            mode_d  = pri_s;
                        end else begin
                            mode_d  = MODE_NONE;
                            div_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_GAP: begin
                if (step_en_s) begin
                    if (gap_q == GAP_LAST) begin
                        if (pri_s != MODE_NONE) begin
                            mode_d  = pri_s;
                            step_d  = 2'd0;
                            state_d = ST_RUN;
                        end else begin
                            mode_d  = MODE_NONE;
                            div_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    gap_d = gap_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_NONE;
                div_d   = '0;
            end
        endcase
    end

    assign bus.step_en   = step_en_s;
    assign bus.fsm_left  = mode_q[0];
    assign bus.fsm_right = mode_q[1];
    assign bus.mode      = mode_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.seq_count = seq_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: two instances (one dark gap step / no gap)
// driven with identical requests and compared every cycle against a
// tick-based reference model, plus a vector table and corner sequences.
module tb_turn_signal_ctrl;

    localparam int SD = 4;

    logic clk = 1'b0;
    logic reset;
    logic l_r, r_r, h_r;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    turn_signal_if if1();
    turn_signal_if if0();

    assign if1.left_req   = l_r;
    assign if1.right_req  = r_r;
    assign if1.hazard_req = h_r;
    assign if0.left_req   = l_r;
    assign if0.right_req  = r_r;
    assign if0.hazard_req = h_r;

    turn_signal_ctrl #(.STEP_DIV(SD), .DIV_W(3), .GAP_STEPS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    turn_signal_ctrl #(.STEP_DIV(SD), .DIV_W(3), .GAP_STEPS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );

    // Reference model: a busy flag and one tick counter measured from the
    // start of the current sequence; every output follows from arithmetic
    // on that tick.
    typedef struct {
        logic [2:0] s1;
        logic [2:0] s2;
        bit         busy;
        logic [1:0] lat;
        int         tick;
        int         seq;
    } model_t;

    model_t m1, m0;

    function automatic logic [1:0] ref_arb(input logic [2:0] q);
        if (q[2] || (q[1] && q[0])) return 2'b11;
        if (q[0]) return 2'b01;
        if (q[1]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic model_t model_clear();
        model_t m;
        m.s1 = 3'b000; m.s2 = 3'b000; m.busy = 1'b0;
        m.lat = 2'b00; m.tick = 0; m.seq = 0;
        return m;
    endfunction

    function automatic model_t model_edge(model_t m, int gap, logic [2:0] raw, logic rst);
        model_t     n;
        logic [1:0] pri;
        int         period;
        if (rst) return model_clear();
        n      = m;
        pri    = ref_arb(m.s2);
        period = (4 + gap) * SD;
        if (!m.busy) begin
            if (pri != 2'b00) begin
                n.busy = 1'b1; n.lat = pri; n.tick = 0;
            end
        end else begin
            if (m.tick == 4 * SD - 1 && m.seq < 255) n.seq = m.seq + 1;
            if (m.tick == period - 1) begin
                n.tick = 0;
                if (pri != 2'b00) n.lat = pri;
                else              n.busy = 1'b0;
            end else begin
                n.tick = m.tick + 1;
            end
        end
        n.s2 = m.s1;
        n.s1 = raw;
        return n;
    endfunction

    function automatic int m_mode(model_t m);
        return (m.busy && m.tick < 4 * SD) ? int'(m.lat) : 0;
    endfunction

    function automatic int m_step(model_t m);
        return (m.busy && (m.tick % SD == SD - 1)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_models();
        chk("g1_mode",  int'(if1.mode),      m_mode(m1));
        chk("g1_left",  int'(if1.fsm_left),  m_mode(m1) % 2);
        chk("g1_right", int'(if1.fsm_right), m_mode(m1) / 2);
        chk("g1_step",  int'(if1.step_en),   m_step(m1));
        chk("g1_busy",  int'(if1.busy),      int'(m1.busy));
        chk("g1_seq",   int'(if1.seq_count), m1.seq);
        chk("g0_mode",  int'(if0.mode),      m_mode(m0));
        chk("g0_left",  int'(if0.fsm_left),  m_mode(m0) % 2);
        chk("g0_right", int'(if0.fsm_right), m_mode(m0) / 2);
        chk("g0_step",  int'(if0.step_en),   m_step(m0));
        chk("g0_busy",  int'(if0.busy),      int'(m0.busy));
        chk("g0_seq",   int'(if0.seq_count), m0.seq);
    endtask

    // One clock: models advance on the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        m1 = model_edge(m1, 1, {h_r, r_r, l_r}, reset);
        m0 = model_edge(m0, 0, {h_r, r_r, l_r}, reset);
        @(negedge clk);
        compare_models();
    endtask

    task automatic set_rst(input logic v);
        reset = v;
        if (v) begin
            m1 = model_clear();
            m0 = model_clear();
        end
    endtask

    task automatic set_req(input logic [2:0] v);
        {h_r, r_r, l_r} = v;
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] req;
        int         n;
        logic [1:0] mode;
        logic       busy;
        logic       step;
        int         seq;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int pulses;
        int last_pulse;
        int bad_gap;
        int bad_mode;

        set_req(3'b000);
        set_rst(1'b1);

        // {reset, {haz,right,left}, cycles, mode, busy, step_en, seq_count} for the gap-of-one instance
        tbl[0]  = '{1'b1, 3'b111,  3, 2'b00, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 3'b111,  2, 2'b00, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 3'b111,  1, 2'b11, 1'b1, 1'b0, 0};
        tbl[3]  = '{1'b1, 3'b000,  1, 2'b00, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 3'b001,  3, 2'b01, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b0, 3'b001,  3, 2'b01, 1'b1, 1'b1, 0};
        tbl[6]  = '{1'b0, 3'b001,  1, 2'b01, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 3'b001, 11, 2'b01, 1'b1, 1'b1, 0};
        tbl[8]  = '{1'b0, 3'b001,  1, 2'b00, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b0, 3'b001,  3, 2'b00, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b0, 3'b001,  1, 2'b01, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b0, 3'b000, 16, 2'b00, 1'b1, 1'b0, 2};
        tbl[12] = '{1'b0, 3'b000,  4, 2'b00, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b0, 3'b000, 10, 2'b00, 1'b0, 1'b0, 2};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            set_req(tbl[i].req);
            set_rst(tbl[i].rst);
            repeat (tbl[i].n) cycle();
            chk($sformatf("tbl%0d_mode", i),  int'(if1.mode),      int'(tbl[i].mode));
            chk($sformatf("tbl%0d_left", i),  int'(if1.fsm_left),  int'(tbl[i].mode[0]));
            chk($sformatf("tbl%0d_right", i), int'(if1.fsm_right), int'(tbl[i].mode[1]));
            chk($sformatf("tbl%0d_busy", i),  int'(if1.busy),      int'(tbl[i].busy));
            chk($sformatf("tbl%0d_step", i),  int'(if1.step_en),   int'(tbl[i].step));
            chk($sformatf("tbl%0d_seq", i),   int'(if1.seq_count), tbl[i].seq);
        end

        // Right pulse of 6 cycles: one full sequence plus one gap pulse, then idle.
        set_rst(1'b1); cycle(); set_rst(1'b0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            set_req((i < 6) ? 3'b010 : 3'b000);
            cycle();
            if (if1.step_en) pulses++;
        end
        chk("release_pulses", pulses, 5);
        chk("release_busy", int'(if1.busy), 0);
        chk("release_seq", int'(if1.seq_count), 1);

        // Hazard raised during the second step of a left sequence.
        set_rst(1'b1); cycle(); set_rst(1'b0);
        set_req(3'b001);
        repeat (3) cycle();
        repeat (5) cycle();
        set_req(3'b101);
        repeat (10) cycle();
        chk("preempt_hold_mode", int'(if1.mode), 1);
        chk("preempt_hold_right", int'(if1.fsm_right), 0);
        cycle();
        chk("preempt_gap_mode", int'(if1.mode), 0);
        repeat (4) cycle();
        chk("preempt_new_mode", int'(if1.mode), 3);
        chk("preempt_left", int'(if1.fsm_left), 1);
        chk("preempt_right", int'(if1.fsm_right), 1);

        // Left+right with no gap: hazard mode, step_en every SD cycles.
        set_rst(1'b1); cycle(); set_rst(1'b0);
        set_req(3'b011);
        repeat (3) cycle();
        pulses = 0; last_pulse = -1; bad_gap = 0; bad_mode = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (if0.mode != 2'b11) bad_mode++;
            if (if0.step_en) begin
                if (last_pulse >= 0 && i - last_pulse != SD) bad_gap++;
                last_pulse = i;
                pulses++;
            end
        end
        chk("nogap_pulses", pulses, 10);
        chk("nogap_spacing", bad_gap, 0);
        chk("nogap_mode", bad_mode, 0);

        // Asynchronous reset while step_cnt == 2.
        set_rst(1'b1); cycle(); set_rst(1'b0);
        set_req(3'b001);
        repeat (12) cycle();
        #2;
        set_rst(1'b1);
        #1;
        chk("async_mode", int'(if1.mode), 0);
        chk("async_busy", int'(if1.busy), 0);
        chk("async_step", int'(if1.step_en), 0);
        chk("async_left", int'(if1.fsm_left), 0);
        chk("async_seq", int'(if0.seq_count), 0);
        cycle();
        set_rst(1'b0);

        // Saturation: more than 255 back-to-back sequences.
        set_req(3'b001);
        repeat (300 * 4 * SD + 10) cycle();
        chk("sat_seq0", int'(if0.seq_count), 255);

        // Random requests (held for random spans) and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) set_req(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 499) == 0) set_rst(1'b1);
            else set_rst(1'b0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
